// File: rtl/qc_timestamp_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : qc_timestamp_dispatcher
// Brief    : Issue window that releases instructions onto NUM_PORTS dispatch
//            slots once their start_time is due. Optional macro
//            QC_QUBIT_CONFLICT_CHECK_EN holds back same-cycle qubit overlaps.
// Revision : 1.0 - initial release
// ============================================================================

module qc_timestamp_dispatcher #(
  parameter int NUM_FPGA           = 64,
  parameter int NUM_QUBIT_PER_FPGA = 64,
  parameter int NUM_REGS_L1        = 16,
  parameter int NUM_PORTS          = 4,
  parameter int TS_W               = 16,
  localparam int c_QW    = $clog2(NUM_FPGA * NUM_QUBIT_PER_FPGA),
  localparam int c_IW    = 2 + 3 * c_QW + TS_W,
  localparam int c_OCC_W = $clog2(NUM_REGS_L1 + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [c_IW-1:0]             in_instr,
  output logic [NUM_PORTS-1:0]        disp_valid,
  input  logic [NUM_PORTS-1:0]        disp_ready,
  output logic [NUM_PORTS*c_IW-1:0]   disp_instr,
  output logic [TS_W-1:0]             curr_timestamp,
  output logic [c_OCC_W-1:0]          occupancy,
  output logic [15:0]                 late_count
);

  localparam int         c_IDX_W         = $clog2(NUM_REGS_L1);
  localparam logic [1:0] c_MODE_EMPTY    = 2'd0;
  localparam logic [1:0] c_MODE_DISPATCH = 2'd1;
  localparam logic [1:0] c_MODE_ADVANCE  = 2'd2;

  logic [c_IW-1:0]          r_win [NUM_REGS_L1];
  logic [NUM_REGS_L1-1:0]   r_wv;
  logic [c_IW-1:0]          r_dw  [NUM_PORTS];
  logic [NUM_PORTS-1:0]     r_dv;
  logic [TS_W-1:0]          r_ts;
  logic [c_OCC_W-1:0]       r_occ;
  logic [15:0]              r_late;

  logic [NUM_REGS_L1-1:0]   w_elig;
  logic [NUM_REGS_L1-1:0]   w_alloc;
  logic [NUM_PORTS-1:0]     w_free;
  logic [NUM_PORTS-1:0]     w_pv;
  logic [c_IW-1:0]          w_pw  [NUM_PORTS];
  logic [c_OCC_W-1:0]       w_nalloc;
  int                       w_prank [NUM_PORTS];
  int                       w_erank [NUM_REGS_L1];
  logic [TS_W-1:0]          w_min;
  logic [c_IDX_W-1:0]       w_wr_idx;
  logic [1:0]               w_mode;
  logic                     w_acc;

`ifdef QC_QUBIT_CONFLICT_CHECK_EN
  function automatic logic qubit_overlap(input logic [c_IW-1:0] a, input logic [c_IW-1:0] b);
    logic [c_QW-1:0] qa [3];
    logic [c_QW-1:0] qb [3];
    logic            hit;
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      qa[k] = a[TS_W + k*c_QW +: c_QW];
      qb[k] = b[TS_W + k*c_QW +: c_QW];
    end
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++)
        if (qa[x] == qb[y]) hit = 1'b1;
    return hit;
  endfunction
`endif

  assign in_ready = (r_occ != c_OCC_W'(NUM_REGS_L1));
  assign w_acc    = in_valid && in_ready;
  assign w_free   = ~r_dv | disp_ready;

  generate
    for (genvar i = 0; i < NUM_REGS_L1; i++) begin : g_elig
      assign w_elig[i] = r_wv[i] && (r_win[i][TS_W-1:0] <= r_ts);
    end
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_out
      assign disp_instr[p*c_IW +: c_IW] = r_dw[p];
    end
  endgenerate

  // Eligible entries take free ports in ascending order: k-th paired entry
  // goes to the k-th free port.
  always_comb begin : p_alloc
    int   n_free;
    int   n_pair;
    logic hit;
    n_free  = 0;
    n_pair  = 0;
    hit     = 1'b0;
    w_alloc = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_prank[p] = n_free;
      if (w_free[p]) n_free = n_free + 1;
    end
    for (int i = 0; i < NUM_REGS_L1; i++) begin
      w_erank[i] = 0;
      hit        = 1'b0;
`ifdef QC_QUBIT_CONFLICT_CHECK_EN
      for (int j = 0; j < NUM_REGS_L1; j++)
        if (j < i && w_alloc[j] && qubit_overlap(r_win[i], r_win[j])) hit = 1'b1;
`endif
      if (w_elig[i] && !hit && (n_pair < n_free)) begin
        w_alloc[i] = 1'b1;
        w_erank[i] = n_pair;
        n_pair     = n_pair + 1;
      end
    end
    w_nalloc = c_OCC_W'(n_pair);
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_pv[p] = 1'b0;
      w_pw[p] = '0;
      for (int i = 0; i < NUM_REGS_L1; i++) begin
        if (w_free[p] && w_alloc[i] && (w_erank[i] == w_prank[p])) begin
          w_pv[p] = 1'b1;
          w_pw[p] = r_win[i];
        end
      end
    end
  end

  always_comb begin : p_min_ts
    w_min = '1;
    for (int i = 0; i < NUM_REGS_L1; i++)
      if (r_wv[i] && (r_win[i][TS_W-1:0] < w_min)) w_min = r_win[i][TS_W-1:0];
  end

  // Slot choice looks only at registered valid bits; slots freed this cycle wait.
  always_comb begin : p_free_slot
    w_wr_idx = '0;
    for (int i = NUM_REGS_L1 - 1; i >= 0; i--)
      if (!r_wv[i]) w_wr_idx = c_IDX_W'(i);
  end

  always_comb begin : p_mode
    if (r_occ == '0)
      w_mode = c_MODE_EMPTY;
    else if (|w_elig)
      w_mode = c_MODE_DISPATCH;
    else
      w_mode = c_MODE_ADVANCE;
  end

  always_ff @(posedge clk) begin : p_ctrl
    if (rst) begin
      r_wv   <= '0;
      r_dv   <= '0;
      r_ts   <= '0;
      r_occ  <= '0;
      r_late <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS_L1; i++)
        if (w_alloc[i]) r_wv[i] <= 1'b0;
      if (w_acc) r_wv[w_wr_idx] <= 1'b1;
      for (int p = 0; p < NUM_PORTS; p++)
        if (w_free[p]) r_dv[p] <= w_pv[p];
      r_occ <= r_occ + c_OCC_W'(w_acc) - w_nalloc;
      if (w_mode == c_MODE_ADVANCE) r_ts <= w_min;
      if (w_acc && (in_instr[TS_W-1:0] < r_ts) && (r_late != 16'hFFFF))
        r_late <= r_late + 16'd1;
    end
  end

  always_ff @(posedge clk) begin : p_data
    if (w_acc) r_win[w_wr_idx] <= in_instr;
    for (int p = 0; p < NUM_PORTS; p++)
      if (w_free[p] && w_pv[p]) r_dw[p] <= w_pw[p];
  end

  assign disp_valid     = r_dv;
  assign curr_timestamp = r_ts;
  assign occupancy      = r_occ;
  assign late_count     = r_late;

endmodule

`default_nettype wire

// File: tb/tb_qc_timestamp_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qc_timestamp_dispatcher
// Brief    : Directed + randomized bench against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_qc_timestamp_dispatcher;

  localparam int NF  = 64;
  localparam int NQ  = 64;
  localparam int NR  = 16;
  localparam int NP  = 4;
  localparam int TSW = 16;
  localparam int QW  = $clog2(NF * NQ);
  localparam int W   = 2 + 3 * QW + TSW;
  localparam int OW  = $clog2(NR + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_instr = '0;
  logic [NP-1:0]   disp_valid;
  logic [NP-1:0]   disp_ready = '0;
  logic [NP*W-1:0] disp_instr;
  logic [TSW-1:0]  curr_timestamp;
  logic [OW-1:0]   occupancy;
  logic [15:0]     late_count;

  always #5 clk = ~clk;

  qc_timestamp_dispatcher #(
    .NUM_FPGA(NF), .NUM_QUBIT_PER_FPGA(NQ), .NUM_REGS_L1(NR),
    .NUM_PORTS(NP), .TS_W(TSW)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_instr(disp_instr), .curr_timestamp(curr_timestamp),
    .occupancy(occupancy), .late_count(late_count)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit           m_live = 1'b0;
  bit           m_wv [NR];
  logic [W-1:0] m_ww [NR];
  bit           m_dv [NP];
  logic [W-1:0] m_dw [NP];
  int           m_ts = 0;
  int           m_late = 0;
  int           delivered [4096];

  function automatic logic [W-1:0] mk(int op, int a, int b, int d, int t);
    return {2'(op), QW'(a), QW'(b), QW'(d), TSW'(t)};
  endfunction
  function automatic logic [W-1:0] w_id(int id, int t);
    return mk(0, id, 2048 + id, 1024 + id, t);
  endfunction
  function automatic int st(logic [W-1:0] w);
    return int'(w[TSW-1:0]);
  endfunction
  function automatic int op1(logic [W-1:0] w);
    return int'(w[TSW+2*QW +: QW]);
  endfunction
  function automatic logic [W-1:0] port_word(int p);
    return disp_instr[p*W +: W];
  endfunction
  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_wv[i]);
    return c;
  endfunction
`ifdef QC_QUBIT_CONFLICT_CHECK_EN
  function automatic bit overlaps(logic [W-1:0] a, logic [W-1:0] b);
    int qa [3];
    int qb [3];
    qa = '{op1(a), int'(a[TSW+QW +: QW]), int'(a[TSW +: QW])};
    qb = '{op1(b), int'(b[TSW+QW +: QW]), int'(b[TSW +: QW])};
    foreach (qa[x]) foreach (qb[y]) if (qa[x] == qb[y]) return 1'b1;
    return 1'b0;
  endfunction
`endif

  task automatic m_step();
    int           elig [$];
    int           freep [$];
    logic [W-1:0] paired [$];
    int           cnt, k, slot, new_ts;
    bit           acc, skip;
    if (rst) begin
      foreach (m_wv[i]) m_wv[i] = 1'b0;
      foreach (m_dv[p]) m_dv[p] = 1'b0;
      m_ts = 0; m_late = 0; m_live = 1'b1;
      return;
    end
    cnt = m_count();
    for (int i = 0; i < NR; i++) if (m_wv[i] && st(m_ww[i]) <= m_ts) elig.push_back(i);
    for (int p = 0; p < NP; p++) if (!m_dv[p] || disp_ready[p]) freep.push_back(p);
    new_ts = m_ts;
    if (cnt > 0 && elig.size() == 0) begin
      new_ts = 1 << TSW;
      for (int i = 0; i < NR; i++) if (m_wv[i] && st(m_ww[i]) < new_ts) new_ts = st(m_ww[i]);
    end
    acc  = in_valid && (cnt != NR);
    slot = -1;
    for (int i = NR - 1; i >= 0; i--) if (!m_wv[i]) slot = i;
    k = 0;
    foreach (elig[e]) begin
      if (k < freep.size()) begin
        skip = 1'b0;
`ifdef QC_QUBIT_CONFLICT_CHECK_EN
        foreach (paired[q]) if (overlaps(m_ww[elig[e]], paired[q])) skip = 1'b1;
`endif
        if (!skip) begin
          m_dw[freep[k]] = m_ww[elig[e]];
          m_dv[freep[k]] = 1'b1;
          paired.push_back(m_ww[elig[e]]);
          m_wv[elig[e]] = 1'b0;
          k++;
        end
      end
    end
    for (int kk = k; kk < freep.size(); kk++) m_dv[freep[kk]] = 1'b0;
    if (acc) begin
      if (st(in_instr) < m_ts && m_late < 65535) m_late++;
      m_wv[slot] = 1'b1;
      m_ww[slot] = in_instr;
    end
    m_ts = new_ts;
  endtask

  task automatic compare_model();
    int cnt;
    cnt = m_count();
    check("in_ready", 64'(in_ready), 64'(cnt != NR));
    check("occupancy", 64'(occupancy), 64'(cnt));
    check("curr_timestamp", 64'(curr_timestamp), 64'(m_ts));
    check("late_count", 64'(late_count), 64'(m_late));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("disp_valid[%0d]", p), 64'(disp_valid[p]), 64'(m_dv[p]));
      if (m_dv[p]) check($sformatf("disp_instr[%0d]", p), 64'(port_word(p)), 64'(m_dw[p]));
    end
  endtask

  // One clock: drive, compare at negedge, advance model, return #1 after posedge.
  task automatic cyc(input bit v, input logic [W-1:0] w, input logic [NP-1:0] rdy, input bit r);
    rst = r; in_valid = v; in_instr = w; disp_ready = rdy;
    @(negedge clk);
    if (m_live) compare_model();
    for (int p = 0; p < NP; p++)
      if (disp_valid[p] && disp_ready[p]) delivered[op1(port_word(p))]++;
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NP-1:0] rdy);
    cyc(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '1, 1'b1);
    cyc(1'b0, '0, '1, 1'b1);
    rst = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] w, input logic [NP-1:0] rdy);
    int  budget = 0;
    bit  done = 1'b0;
    while (!done) begin
      done = in_ready;
      cyc(1'b1, w, rdy, 1'b0);
      budget++;
      if (!done && budget > 200) begin
        check("push_timeout", 64'(0), 64'(1));
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget = 0;
    while ((occupancy != 0 || disp_valid != 0) && budget < 200) begin
      idle('1);
      budget++;
    end
    check({tag, "_drained"}, 64'(budget < 200), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (delivered[i]) delivered[i] = 0;

    // Reset then idle
    do_reset();
    idle('1);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_disp_valid", 64'(disp_valid), 64'(0));
    check("rst_ts", 64'(curr_timestamp), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_late", 64'(late_count), 64'(0));

    // ts 5,5,9: both 5s leave together, then advance to 9
    push(w_id(1, 5), '1);
    push(w_id(2, 5), '1);
    push(w_id(3, 9), '1);
    check("ts5_valid", 64'(disp_valid[1:0]), 64'(2'b11));
    check("ts5_p0", 64'(op1(port_word(0))), 64'(1));
    check("ts5_p1", 64'(op1(port_word(1))), 64'(2));
    check("ts5_ts", 64'(curr_timestamp), 64'(5));
    idle('1);
    check("ts9_ts", 64'(curr_timestamp), 64'(9));
    check("ts9_gap", 64'(disp_valid), 64'(0));
    idle('1);
    check("ts9_valid", 64'(disp_valid), 64'(4'b0001));
    check("ts9_p0", 64'(op1(port_word(0))), 64'(3));
    check("ts9_occ", 64'(occupancy), 64'(0));

    // Late word
    push(w_id(4, 3), '1);
    check("late_cnt", 64'(late_count), 64'(1));
    idle('1);
    check("late_disp", 64'(disp_valid), 64'(4'b0001));
    check("late_p0", 64'(op1(port_word(0))), 64'(4));
    check("late_ts", 64'(curr_timestamp), 64'(9));

    // Backpressure fill then drain
    do_reset();
    foreach (delivered[i]) delivered[i] = 0;
    for (int id = 10; id < 30; id++) push(w_id(id, 0), '0);
    for (int n = 0; n < 3; n++) cyc(1'b1, w_id(30, 0), '0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_occ", 64'(occupancy), 64'(NR));
    check("bp_ports", 64'(disp_valid), 64'(4'hF));
    push(w_id(30, 0), '1);
    drain("bp");
    for (int id = 10; id <= 30; id++)
      check($sformatf("bp_once_%0d", id), 64'(delivered[id]), 64'(1));

    // Six ts=7 words buffered behind busy ports
    do_reset();
    for (int id = 40; id < 50; id++) push(w_id(id, 7), '0);
    for (int n = 0; n < 3; n++) idle('0);
    check("six_occ", 64'(occupancy), 64'(6));
    idle('1);
    check("six_first", 64'(disp_valid), 64'(4'hF));
    check("six_first_occ", 64'(occupancy), 64'(2));
    check("six_first_ts", 64'(curr_timestamp), 64'(7));
    idle('1);
    check("six_second", 64'(disp_valid), 64'(4'b0011));
    check("six_second_occ", 64'(occupancy), 64'(0));
    check("six_second_ts", 64'(curr_timestamp), 64'(7));

    // Two ts=2 words sharing dest 12
    do_reset();
    push(mk(1, 100, 101, 12, 2), '1);
    push(mk(1, 200, 201, 12, 2), '1);
    idle('1);
`ifdef QC_QUBIT_CONFLICT_CHECK_EN
    check("conf_first", 64'(disp_valid), 64'(4'b0001));
    idle('1);
    check("conf_second", 64'(disp_valid), 64'(4'b0001));
    check("conf_second_p0", 64'(op1(port_word(0))), 64'(200));
`else
    check("conf_both", 64'(disp_valid), 64'(4'b0011));
    check("conf_p1", 64'(op1(port_word(1))), 64'(200));
    idle('1);
    check("conf_after", 64'(disp_valid), 64'(0));
`endif
    check("conf_occ", 64'(occupancy), 64'(0));

    // Reset mid-drain
    do_reset();
    for (int id = 60; id < 69; id++) push(w_id(id, 3), '0);
    for (int n = 0; n < 4; n++) idle('0);
    check("mid_occ", 64'(occupancy), 64'(5));
    check("mid_ts", 64'(curr_timestamp), 64'(3));
    cyc(1'b1, w_id(70, 3), '1, 1'b1);
    rst = 1'b0;
    check("mid_rst_occ", 64'(occupancy), 64'(0));
    check("mid_rst_dv", 64'(disp_valid), 64'(0));
    check("mid_rst_ts", 64'(curr_timestamp), 64'(0));

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1200; n++) begin
      int t;
      t = m_ts + int'($urandom_range(0, 6)) - 1;
      if (t < 0) t = 0;
      cyc(1'($urandom_range(0, 1)),
          mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), t),
          NP'($urandom), ($urandom_range(0, 299) == 0));
    end
    drain("rand");
    idle('1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qc_timestamp_dispatcher.md
Name: qc_timestamp_dispatcher

Overview:
- Parametrised successor to the quantum instruction scheduler.
- Accepts a stream of quantum instruction words, holds them in an NUM_REGS_L1-entry issue window (layer 1), and tracks a current timestamp.
- Moves every instruction whose start_time is due into NUM_PORTS registered dispatch slots (layer 2) that feed the functional units over valid/ready.

Parameters:
NUM_FPGA, 64, FPGA count; with NUM_QUBIT_PER_FPGA sets qubit address width QW = $clog2(NUM_FPGA*NUM_QUBIT_PER_FPGA)
NUM_QUBIT_PER_FPGA, 64, qubits per FPGA
NUM_REGS_L1, 16, issue-window entries (>=2)
NUM_PORTS, 4, dispatch ports to functional units (>=1)
TS_W, 16, start_time / timestamp width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_instr valid
in_ready  out  1  window can accept
in_instr  in  2+3*QW+TS_W  {op_code[1:0], op_1, op_2, dest, start_time}, MSB to LSB
disp_valid  out  NUM_PORTS  per-port instruction valid
disp_ready  in  NUM_PORTS  per-port functional-unit ready
disp_instr  out  NUM_PORTS*(2+3*QW+TS_W)  per-port instruction word; port p at slice p
curr_timestamp  out  TS_W  current dominant timestamp
occupancy  out  $clog2(NUM_REGS_L1+1)  valid window entries
late_count  out  16  instructions accepted with start_time < curr_timestamp; saturates at 16'hFFFF

Behaviour:
- Reset (rst=1 at an edge): all window valid bits, disp_valid, curr_timestamp, occupancy and late_count go to 0.
- Reset wins over any same-cycle accept or dispatch. Instructions in flight are discarded; no partial state survives.
- Accept:
  - in_ready = (occupancy != NUM_REGS_L1), from registered state only; no same-cycle bypass of freed slots.
  - On in_valid & in_ready, the word is written into the lowest-index free entry at that edge.
  - late_count increments if start_time < curr_timestamp.
- Eligibility: an entry is eligible when valid and start_time <= curr_timestamp, using unsigned compare with no wrap handling.
- Port free: a port is free in a cycle when !disp_valid[p] | disp_ready[p].
- Allocation each cycle:
  - Eligible entries, in ascending entry index, are paired with free ports, in ascending port index.
  - Each paired entry is copied to its port register and invalidated at the edge; disp_valid[p] <= 1.
  - A free port with no paired entry gets disp_valid[p] <= 0.
  - An unfree port holds its word.
- Latency: an accepted word is in the window after edge N. It is evaluated in cycle N+1, so disp_valid is asserted earliest after edge N+1 (2 cycles in to out).
- occupancy(next) = occupancy + accepted - allocated. Accept and allocate in the same cycle are legal, including at full: the freed slot becomes usable next cycle.
- Timestamp mode, derived each cycle:
  - EMPTY: occupancy==0; curr_timestamp holds.
  - DISPATCH: at least one eligible entry; curr_timestamp holds.
  - ADVANCE: occupancy>0 and no eligible entry; curr_timestamp <= minimum start_time over valid entries. The entry written this same cycle is excluded from the minimum.
- curr_timestamp never decreases. It only moves to a value some buffered instruction needs; no idle ticking.
- Backpressure: with all disp_ready=0 and all ports valid, nothing is allocated and the window fills. in_ready drops at NUM_REGS_L1.
- Every instruction is dispatched exactly once. Order within one timestamp follows window index, not arrival order.

Optional Feature:
- Macro: QC_QUBIT_CONFLICT_CHECK_EN.
- With the macro defined: during allocation, an eligible entry is skipped (left in the window) if any of its op_1/op_2/dest matches any op_1/op_2/dest of an entry already paired in the same cycle. It retries next cycle, and curr_timestamp does not advance while it is pending.
- Without the macro: no operand comparison; allocation as above.

Test Plan:
- Reset then idle -> in_ready=1, disp_valid=0, curr_timestamp=0, occupancy=0, late_count=0.
- Push 3 words with start_time 5,5,9, ports always ready:
  - curr_timestamp advances to 5; both ts=5 words appear on ports 0 and 1 in the same cycle.
  - Then curr_timestamp=9 and the ts=9 word appears on port 0; occupancy returns to 0.
- Hold disp_ready=0 and push NUM_REGS_L1+NUM_PORTS+1 words with ts=0:
  - Ports fill, occupancy reaches 16, in_ready=0, and the last word stalls.
  - Release disp_ready: all words drain with no loss or duplication.
- After curr_timestamp=9, push a word with ts=3 -> late_count=1; dispatched without timestamp change.
- Push 6 eligible ts=7 words with NUM_PORTS=4 -> 4 dispatched in one cycle, the remaining 2 next cycle; curr_timestamp stays 7 throughout.
- With QC_QUBIT_CONFLICT_CHECK_EN: two ts=2 words sharing dest=12 -> dispatched in consecutive cycles. Without the macro -> same cycle, ports 0 and 1.
- Assert rst mid-drain with occupancy=5 -> next cycle occupancy=0, disp_valid=0, curr_timestamp=0.
